// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps key press edges onto a small pool
// of oscillator voices, stealing the oldest voice when all are busy.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    Enable,
  input  logic [7:0]              keys,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [3*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic                    steal
);

  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

  logic [7:0]                       keys_q;
  logic [7:0]                       pending_q;
  logic [NUM_VOICES-1:0]            gate_q;
  logic [NUM_VOICES-1:0][2:0]       note_q;
  logic [NUM_VOICES-1:0][AGE_W-1:0] age_q;
  logic [NUM_VOICES-1:0]            trig_q;
  logic                             steal_q;

  logic [7:0]                       rise;
  logic [7:0]                       fall;
  logic [7:0]                       cand;
  logic [NUM_VOICES-1:0]            gate_rel;
  logic                             found;
  logic [2:0]                       key_k;
  logic                             has_free;
  logic [2:0]                       free_v;
  logic [2:0]                       old_v;
  logic [AGE_W-1:0]                 old_age;
  logic [2:0]                       tgt;

  logic [7:0]                       pending_d;
  logic [NUM_VOICES-1:0]            gate_d;
  logic [NUM_VOICES-1:0][2:0]       note_d;
  logic [NUM_VOICES-1:0][AGE_W-1:0] age_d;
  logic [NUM_VOICES-1:0]            trig_d;
  logic                             steal_d;

  always_comb begin
    rise = keys & ~keys_q;
    fall = ~keys & keys_q;
    cand = (pending_q | rise) & keys;
    for (int v = 0; v < NUM_VOICES; v++)
      gate_rel[v] = gate_q[v] & ~fall[note_q[v]];
  end

  always_comb begin
    found = 1'b0;
    key_k = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!found && cand[i]) begin
        found = 1'b1;
        key_k = 3'(i);
      end
    end
  end

  // Voices freed by release this edge count as free before any steal.
  always_comb begin
    has_free = 1'b0;
    free_v   = 3'd0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!has_free && !gate_rel[v]) begin
        has_free = 1'b1;
        free_v   = 3'(v);
      end
    end
  end

  always_comb begin
    old_v   = 3'd0;
    old_age = age_q[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_q[v] > old_age) begin
        old_v   = 3'(v);
        old_age = age_q[v];
      end
    end
    tgt = has_free ? free_v : old_v;
  end

  always_comb begin
    pending_d = cand;
    gate_d    = gate_rel;
    note_d    = note_q;
    age_d     = age_q;
    trig_d    = '0;
    steal_d   = 1'b0;
    if (found) begin
      pending_d = cand & ~(8'b1 << key_k);
      steal_d   = ~has_free;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (3'(v) == tgt) begin
          gate_d[v] = 1'b1;
          note_d[v] = key_k;
          age_d[v]  = '0;
          trig_d[v] = 1'b1;
        end else if (gate_rel[v] && age_q[v] != AGE_MAX) begin
          age_d[v] = age_q[v] + AGE_ONE;
        end
      end
    end
    if (!Enable) begin
      pending_d = '0;
      gate_d    = '0;
      note_d    = note_q;
      age_d     = age_q;
      trig_d    = '0;
      steal_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      keys_q    <= '0;
      pending_q <= '0;
      gate_q    <= '0;
      note_q    <= '0;
      age_q     <= '0;
      trig_q    <= '0;
      steal_q   <= 1'b0;
    end else begin
      keys_q    <= keys;
      pending_q <= pending_d;
      gate_q    <= gate_d;
      note_q    <= note_d;
      age_q     <= age_d;
      trig_q    <= trig_d;
      steal_q   <= steal_d;
    end
  end

  assign voice_gate = gate_q;
  assign voice_note = note_q;
  assign voice_trig = trig_q;
  assign steal      = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: expected outputs are queued
// with each stimulus step and checked after the following edge.
module tb_voice_allocator;

  localparam int NV = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          Enable = 1'b1;
  logic [7:0]    keys = 8'h00;
  logic [NV-1:0] voice_gate;
  logic [3*NV-1:0] voice_note;
  logic [NV-1:0] voice_trig;
  logic          steal;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [NV-1:0]   gate;
    logic [3*NV-1:0] note;
    logic [NV-1:0]   trig;
    logic            stl;
  } exp_t;

  exp_t   sb_q[$];
  string  tag_q[$];

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .Enable     (Enable),
    .keys       (keys),
    .voice_gate (voice_gate),
    .voice_note (voice_note),
    .voice_trig (voice_trig),
    .steal      (steal)
  );

  always #10 CLK = ~CLK;

  function automatic logic [3*NV-1:0] nt(int a, int b, int c, int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic step(input string tag, input logic rst,
                      input logic en, input logic [7:0] k,
                      input logic [NV-1:0] g,
                      input logic [3*NV-1:0] n,
                      input logic [NV-1:0] t, input logic s);
    exp_t e;
    string tg;
    RESET  = rst;
    Enable = en;
    keys   = k;
    e.gate = g;
    e.note = n;
    e.trig = t;
    e.stl  = s;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
    e  = sb_q.pop_front();
    tg = tag_q.pop_front();
    n_cmp++;
    assert (voice_gate === e.gate) else begin
      n_bad++;
      $error("FAIL %s gate: got %b want %b", tg, voice_gate, e.gate);
    end
    n_cmp++;
    assert (voice_note === e.note) else begin
      n_bad++;
      $error("FAIL %s note: got %h want %h", tg, voice_note, e.note);
    end
    n_cmp++;
    assert (voice_trig === e.trig) else begin
      n_bad++;
      $error("FAIL %s trig: got %b want %b", tg, voice_trig, e.trig);
    end
    n_cmp++;
    assert (steal === e.stl) else begin
      n_bad++;
      $error("FAIL %s steal: got %b want %b", tg, steal, e.stl);
    end
  endtask

  initial begin
    #1;
    step("rst0", 1, 1, 8'hFF, 4'b0000, nt(0,0,0,0), 4'b0000, 0);
    step("rst1", 1, 1, 8'hFF, 4'b0000, nt(0,0,0,0), 4'b0000, 0);

    step("press", 0, 1, 8'h04, 4'b0001, nt(2,0,0,0), 4'b0001, 0);
    step("hold", 0, 1, 8'h04, 4'b0001, nt(2,0,0,0), 4'b0000, 0);
    step("rel", 0, 1, 8'h00, 4'b0000, nt(2,0,0,0), 4'b0000, 0);

    step("chord0", 0, 1, 8'h0F, 4'b0001, nt(0,0,0,0), 4'b0001, 0);
    step("chord1", 0, 1, 8'h0F, 4'b0011, nt(0,1,0,0), 4'b0010, 0);
    step("chord2", 0, 1, 8'h0F, 4'b0111, nt(0,1,2,0), 4'b0100, 0);
    step("chord3", 0, 1, 8'h0F, 4'b1111, nt(0,1,2,3), 4'b1000, 0);

    step("steal7", 0, 1, 8'h8F, 4'b1111, nt(7,1,2,3), 4'b0001, 1);
    step("stl_one", 0, 1, 8'h8F, 4'b1111, nt(7,1,2,3), 4'b0000, 0);
    step("steal6", 0, 1, 8'hCF, 4'b1111, nt(7,6,2,3), 4'b0010, 1);
    step("relalloc", 0, 1, 8'hEB, 4'b1111, nt(7,6,5,3), 4'b0100, 0);
    step("relall", 0, 1, 8'h00, 4'b0000, nt(7,6,5,3), 4'b0000, 0);

    step("ff0", 0, 1, 8'hFF, 4'b0001, nt(0,6,5,3), 4'b0001, 0);
    step("ff1", 0, 1, 8'hFF, 4'b0011, nt(0,1,5,3), 4'b0010, 0);
    step("drop", 0, 1, 8'h01, 4'b0001, nt(0,1,5,3), 4'b0000, 0);
    step("nokey7", 0, 1, 8'h01, 4'b0001, nt(0,1,5,3), 4'b0000, 0);

    step("dis", 0, 0, 8'h01, 4'b0000, nt(0,1,5,3), 4'b0000, 0);
    step("dis_prs", 0, 0, 8'h09, 4'b0000, nt(0,1,5,3), 4'b0000, 0);
    step("en_held", 0, 1, 8'h09, 4'b0000, nt(0,1,5,3), 4'b0000, 0);
    step("en_held2", 0, 1, 8'h09, 4'b0000, nt(0,1,5,3), 4'b0000, 0);
    step("newprs", 0, 1, 8'h19, 4'b0001, nt(4,1,5,3), 4'b0001, 0);

    step("midrst", 1, 1, 8'h19, 4'b0000, nt(0,0,0,0), 4'b0000, 0);
    step("post0", 0, 1, 8'h19, 4'b0001, nt(0,0,0,0), 4'b0001, 0);
    step("post1", 0, 1, 8'h19, 4'b0011, nt(0,3,0,0), 4'b0010, 0);
    step("post2", 0, 1, 8'h19, 4'b0111, nt(0,3,4,0), 4'b0100, 0);

    n_cmp++;
    assert (sb_q.size() == 0) else begin
      n_bad++;
      $error("FAIL sb_empty: got %0d want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
